// File: rtl/bus_pkg.sv
// +------------------------------------------------------------------+
// | bus_pkg: shared widths and destination codes for bus_dest_regs   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;
  localparam int NUM_R  = 16;

  typedef enum logic [DEST_W-1:0] {
    DEST_R0  = 5'd0,  DEST_R1  = 5'd1,  DEST_R2  = 5'd2,  DEST_R3  = 5'd3,
    DEST_R4  = 5'd4,  DEST_R5  = 5'd5,  DEST_R6  = 5'd6,  DEST_R7  = 5'd7,
    DEST_R8  = 5'd8,  DEST_R9  = 5'd9,  DEST_R10 = 5'd10, DEST_R11 = 5'd11,
    DEST_R12 = 5'd12, DEST_R13 = 5'd13, DEST_R14 = 5'd14, DEST_R15 = 5'd15,
    DEST_HI  = 5'd16, DEST_LO  = 5'd17, DEST_PC  = 5'd18, DEST_MAR = 5'd19
  } dest_e;

  localparam logic [DEST_W-1:0] DEST_LAST_VALID = 5'd19;

  function automatic logic dest_valid(input logic [DEST_W-1:0] dest);
    return dest <= DEST_LAST_VALID;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_write_stage.sv
// +------------------------------------------------------------------+
// | bus_write_stage: one-entry staging register with hold/ready      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bus_write_stage
  import bus_pkg::*;
(
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              wr_valid,
  input  logic [DEST_W-1:0] wr_dest,
  input  logic              hold,
  output logic              wr_ready,
  output logic              commit_valid,
  output logic [DATA_W-1:0] commit_data,
  output logic [DEST_W-1:0] commit_dest
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              w_accept;

  // Ready never looks at wr_valid, so the producer can use it freely.
  assign wr_ready     = !full_q || !hold;
  assign w_accept     = wr_valid && wr_ready;
  assign commit_valid = full_q && !hold;
  assign commit_data  = data_q;
  assign commit_dest  = dest_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    dest_d = dest_q;
    if (commit_valid) begin
      full_d = 1'b0;
    end
    if (w_accept) begin
      full_d = 1'b1;
      data_d = bus_in;
      dest_d = wr_dest;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      dest_q <= dest_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_dest_regs.sv
// +------------------------------------------------------------------+
// | bus_dest_regs: bus-written register bank R0-R15, HI, LO, PC, MAR |
// | Option macro BUS_DEST_R0_ZERO_EN hardwires R0 to zero. Rev 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module bus_dest_regs
  import bus_pkg::*;
(
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [DATA_W-1:0]       bus_in,
  input  logic                    wr_valid,
  input  logic [DEST_W-1:0]       wr_dest,
  output logic                    wr_ready,
  input  logic                    hold,
  input  logic                    pc_inc,
  output logic                    wr_err,
  output logic [NUM_R*DATA_W-1:0] r_out,
  output logic [DATA_W-1:0]       hi_out,
  output logic [DATA_W-1:0]       lo_out,
  output logic [DATA_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       mar_out
);

`ifdef BUS_DEST_R0_ZERO_EN
  localparam bit R0_WRITABLE = 1'b0;
`else
  localparam bit R0_WRITABLE = 1'b1;
`endif

  logic              commit_valid;
  logic [DATA_W-1:0] commit_data;
  logic [DEST_W-1:0] commit_dest;

  logic [DATA_W-1:0] r_q [NUM_R];
  logic [DATA_W-1:0] r_d [NUM_R];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, mar_q, mar_d;
  logic              wr_err_q, wr_err_d;

  bus_write_stage u_stage (
    .clock        (clock),
    .clear_n      (clear_n),
    .bus_in       (bus_in),
    .wr_valid     (wr_valid),
    .wr_dest      (wr_dest),
    .hold         (hold),
    .wr_ready     (wr_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_dest  (commit_dest)
  );

  always_comb begin
    for (int i = 0; i < NUM_R; i++) r_d[i] = r_q[i];
    hi_d     = hi_q;
    lo_d     = lo_q;
    mar_d    = mar_q;
    wr_err_d = 1'b0;
    pc_d     = pc_inc ? pc_q + 32'd4 : pc_q;
    // A bus commit to PC overrides the increment on the same edge.
    if (commit_valid) begin
      if (!dest_valid(commit_dest)) begin
        wr_err_d = 1'b1;
      end else if (!commit_dest[4]) begin
        if (R0_WRITABLE || commit_dest[3:0] != 4'd0) begin
          r_d[commit_dest[3:0]] = commit_data;
        end
      end else begin
        case (commit_dest)
          DEST_HI:  hi_d  = commit_data;
          DEST_LO:  lo_d  = commit_data;
          DEST_PC:  pc_d  = commit_data;
          DEST_MAR: mar_d = commit_data;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_R; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pc_q     <= '0;
      mar_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_R; i++) r_q[i] <= r_d[i];
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      wr_err_q <= wr_err_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_R; g++) begin : g_r_out
      assign r_out[g*DATA_W +: DATA_W] = r_q[g];
    end
  endgenerate

  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign pc_out  = pc_q;
  assign mar_out = mar_q;
  assign wr_err  = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_dest_regs.sv
// +------------------------------------------------------------------+
// | tb_bus_dest_regs: vector table, directed corners, random vs model|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bus_dest_regs;
  import bus_pkg::*;

`ifdef BUS_DEST_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clear_n;
  logic [31:0]  bus_in;
  logic         wr_valid;
  logic [4:0]   wr_dest;
  logic         wr_ready;
  logic         hold;
  logic         pc_inc;
  logic         wr_err;
  logic [511:0] r_out;
  logic [31:0]  hi_out, lo_out, pc_out, mar_out;

  int errors = 0;
  int checks = 0;

  // Reference: 20 architectural registers indexed by destination code,
  // a queue holding at most one pending {dest, data}, and the error flag.
  logic [31:0] m_regs [20];
  logic [36:0] m_q [$];
  logic        m_err;

  always #5 clock = ~clock;

  bus_dest_regs dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .bus_in   (bus_in),
    .wr_valid (wr_valid),
    .wr_dest  (wr_dest),
    .wr_ready (wr_ready),
    .hold     (hold),
    .pc_inc   (pc_inc),
    .wr_err   (wr_err),
    .r_out    (r_out),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .pc_out   (pc_out),
    .mar_out  (mar_out)
  );

  typedef struct {
    logic        v;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        h;
    logic        inc;
    logic        exp_ready;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] m_rout();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 20; i++) m_regs[i] = 32'h0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  function automatic logic m_ready();
    return (m_q.size() == 0) || !hold;
  endfunction

  // Applies the effect of one rising edge given the inputs now driven.
  task automatic m_edge();
    logic        rdy;
    logic        pc_by_bus;
    logic [36:0] e;
    logic [4:0]  d;
    rdy       = m_ready();
    pc_by_bus = 1'b0;
    m_err     = 1'b0;
    if (m_q.size() != 0 && !hold) begin
      e = m_q.pop_front();
      d = e[36:32];
      if (d > 5'd19) m_err = 1'b1;
      else if (!(d == 5'd0 && R0_ZERO)) m_regs[d] = e[31:0];
      if (d == 5'd18) pc_by_bus = 1'b1;
    end
    if (pc_inc && !pc_by_bus) m_regs[18] = m_regs[18] + 32'd4;
    if (wr_valid && rdy) m_q.push_back({wr_dest, bus_in});
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".r_out"}, r_out, m_rout());
    chk({tag, ".hi_lo_pc_mar"}, {hi_out, lo_out, pc_out, mar_out},
        {m_regs[16], m_regs[17], m_regs[18], m_regs[19]});
    chk({tag, ".wr_err"}, wr_err, m_err);
  endtask

  // One clock: drive inputs, check ready before the edge, check outputs after.
  // exp_ready: 0/1 adds a fixed expectation, 2 skips it.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [31:0] data,
                       input logic h, input logic inc, input int exp_ready, input string tag);
    wr_valid = v; wr_dest = d; bus_in = data; hold = h; pc_inc = inc;
    #1;
    chk({tag, ".ready_model"}, wr_ready, m_ready());
    if (exp_ready != 2) chk({tag, ".ready_fixed"}, wr_ready, exp_ready[0]);
    @(posedge clock);
    m_edge();
    #1;
    chk_outputs(tag);
  endtask

  vec_t        tbl [10];
  logic [511:0] snap_r;
  logic [127:0] snap_x;

  initial begin
    clear_n = 1'b0; bus_in = '0; wr_valid = 1'b0; wr_dest = '0; hold = 1'b0; pc_inc = 1'b0;
    m_reset();
    #2;
    chk("reset.ready", wr_ready, 1'b1);
    chk_outputs("reset");
    @(posedge clock); #1;
    clear_n = 1'b1;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 5'd16, 32'h11111111, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 5'd17, 32'h22222222, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 5'd19, 32'h33333333, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd19, 32'h33333333, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 5'd19, 32'h33333333, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 5'd25, 32'h00001234, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].h, tbl[i].inc,
            int'(tbl[i].exp_ready), $sformatf("vec%0d", i));
      if (i == 1) chk("vec.r5_deadbeef", r_out[191:160], 32'hDEADBEEF);
      if (i == 8) chk("vec.err_pulse", wr_err, 1'b1);
      if (i == 9) chk("vec.err_drop", wr_err, 1'b0);
    end

    // Hold with full stage and a competing request.
    cycle(1'b1, 5'd7, 32'h0000AAAA, 1'b0, 1'b0, 1, "hold.acc");
    cycle(1'b1, 5'd8, 32'h0000BBBB, 1'b1, 1'b0, 0, "hold.h1");
    cycle(1'b1, 5'd8, 32'h0000BBBB, 1'b1, 1'b0, 0, "hold.h2");
    chk("hold.r7_frozen", r_out[255:224], 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "hold.rel");
    chk("hold.r7_commit", r_out[255:224], 32'h0000AAAA);
    chk("hold.r8_untouched", r_out[287:256], 32'h0);

    // PC wrap and bus-over-increment priority.
    cycle(1'b1, 5'd18, 32'hFFFFFFFC, 1'b0, 1'b0, 1, "pc.acc");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "pc.load");
    chk("pc.loaded", pc_out, 32'hFFFFFFFC);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1, "pc.wrap");
    chk("pc.wrapped", pc_out, 32'h0);
    cycle(1'b1, 5'd18, 32'h00000100, 1'b0, 1'b0, 1, "pc.acc2");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1, "pc.both");
    chk("pc.bus_wins", pc_out, 32'h00000100);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1, "pc.inc_in_hold");
    chk("pc.inc_in_hold", pc_out, 32'h00000104);

    // Invalid destination.
    cycle(1'b1, 5'd25, 32'h00001234, 1'b0, 1'b0, 1, "err.acc");
    snap_r = r_out; snap_x = {hi_out, lo_out, pc_out, mar_out};
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "err.commit");
    chk("err.high", wr_err, 1'b1);
    chk("err.r_same", r_out, snap_r);
    chk("err.x_same", {hi_out, lo_out, pc_out, mar_out}, snap_x);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "err.after");
    chk("err.low", wr_err, 1'b0);

    // R0 behaviour depends on the build option.
    cycle(1'b1, 5'd0, 32'h0000FFFF, 1'b0, 1'b0, 1, "r0.acc");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "r0.commit");
    chk("r0.value", r_out[31:0], R0_ZERO ? 32'h0 : 32'h0000FFFF);
    chk("r0.no_err", wr_err, 1'b0);

    // Asynchronous clear with an entry pending.
    cycle(1'b1, 5'd3, 32'h00005555, 1'b0, 1'b0, 1, "rst.acc");
    wr_valid = 1'b0;
    #2;
    clear_n = 1'b0;
    #1;
    m_reset();
    chk("rst.async_ready", wr_ready, 1'b1);
    chk("rst.async_all", {r_out[63:0], hi_out, lo_out, pc_out, mar_out, 31'h0, wr_err}, 256'h0);
    chk_outputs("rst.async");
    @(posedge clock); #2;
    clear_n = 1'b1;
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "rst.post1");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1, "rst.post2");
    chk("rst.r3_dropped", r_out[127:96], 32'h0);

    // Randomized traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 2, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_dest_regs.md
BUS_DEST_REGS -- requirements
Module: bus_dest_regs

Interface
REQ-001 The block SHALL have these ports, clock and reset first, one per line: name, direction, width, meaning.
- clock  in  1  sole clock; all state updates on rising edge.
- clear_n  in  1  reset, asynchronous assert, active-low.
- bus_in  in  32  data currently driven on the internal bus.
- wr_valid  in  1  write request present.
- wr_dest  in  5  destination code for the request.
- wr_ready  out  1  block accepts a request this cycle.
- hold  in  1  freezes the commit stage.
- pc_inc  in  1  request PC += 4.
- wr_err  out  1  one-cycle pulse when an invalid destination is committed.
- r_out  out  512  R0..R15 contents, R[i] at bits 32i+31:32i.
- hi_out, lo_out, pc_out, mar_out  out  32 each  HI, LO, PC, MAR contents.
REQ-002 The block SHALL have no parameters: name -- none; default -- n/a; meaning -- widths and codes are fixed by the shared package.

Function
REQ-003 Destination codes SHALL be: 0-15 R0-R15, 16 HI, 17 LO, 18 PC, 19 MAR; 20-31 invalid.
REQ-004 A request SHALL be accepted when wr_valid and wr_ready are both high on a rising edge; bus_in and wr_dest are captured into a one-entry stage register.
REQ-005 wr_ready SHALL equal (stage empty) OR (hold low); it is combinational from state and hold only, never from wr_valid.
REQ-006 A full stage SHALL commit on the first rising edge with hold low; the target register takes the new value on that edge.
REQ-007 Commit latency SHALL be exactly 2 edges from acceptance when hold stays low; back-to-back requests SHALL sustain one write per cycle.
REQ-008 Accept and commit on the same edge SHALL both take effect: the old entry commits and the new entry loads.
REQ-009 While hold is high, the full stage SHALL keep its contents, no register SHALL change through the bus path, and wr_ready SHALL be 0.
REQ-010 Committing an invalid code SHALL write nothing and assert wr_err for exactly the one cycle after that edge.
REQ-011 When pc_inc is high, PC SHALL load PC + 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-012 A bus commit to PC and pc_inc on the same edge SHALL load the bus value; that pc_inc is discarded.
REQ-013 pc_inc SHALL be honoured regardless of hold.
REQ-014 All outputs other than wr_ready SHALL be registered.

Reset
REQ-015 While clear_n is low, all 20 registers SHALL be 0x00000000, the stage empty, wr_err 0 and wr_ready 1, independent of clock.
REQ-016 A stage entry pending when clear_n asserts SHALL be discarded, never committed.

Configuration
REQ-017 Macro BUS_DEST_R0_ZERO_EN: when defined, R0 SHALL read constant 0 and commits to code 0 SHALL be dropped silently (no wr_err); when undefined, R0 SHALL be an ordinary writable register.

Structure
REQ-018 Package bus_pkg SHALL hold the data-width constant (32), the destination-code width (5) and the named codes DEST_R0..DEST_MAR with DEST_LAST_VALID = 19.
REQ-019 The staging register and its ready logic SHALL be a sub-module bus_write_stage; the register bank and PC logic stay in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to code 5, hold 0: r_out[191:160] = 0xDEADBEEF two edges after acceptance; other registers unchanged.
- Hold high with the stage full plus a new request: wr_ready 0; the entry is retained; it commits on the first edge after hold drops.
- PC = 0xFFFFFFFC, pc_inc 1: pc_out = 0x00000000; same edge as a bus commit of 0x100 to code 18 gives pc_out = 0x00000100.
- Commit of code 25 with bus 0x1234: wr_err high for exactly one cycle; all registers unchanged.
- Entry pending and clear_n pulsed low mid-cycle: all outputs 0 immediately; no commit after release.
- Write 0xFFFF to code 0: r_out[31:0] = 0 with BUS_DEST_R0_ZERO_EN defined; 0xFFFF without it.
